// File: rtl/fifol_n_if.sv
// Handshake bundle for the depth-N loopy FIFO.
// Producer side drives D_IN/ENQ, consumer side drives DEQ, either may drive
// CLR. All other signals come from the FIFO.
//
// Handshake: FULL_N/ENQ and EMPTY_N/DEQ behave as ready/valid pairs
// sampled on the rising clock edge.
//  - An enqueue happens when ENQ=1 and FULL_N=1.
//  - A dequeue happens when DEQ=1 and EMPTY_N=1.
//  - FULL_N is the only combinational output. It follows DEQ, so a full FIFO
//    accepts a write in the same cycle as a read.
//  - ENQ must not depend combinationally on FULL_N when DEQ depends on ENQ.
interface fifol_n_if #(
   parameter int width = 1,
   parameter int depth = 4
) ();

   localparam int cnt_w = $clog2(depth + 1);

   logic [width-1:0] D_IN;
   logic             ENQ;
   logic             DEQ;
   logic             CLR;
   logic             FULL_N;
   logic             EMPTY_N;
   logic [width-1:0] D_OUT;
   logic [cnt_w-1:0] COUNT;
   logic             AFULL;
   logic             OVF;
   logic             UDF;

   // The surrounding datapath: it drives the strobes and data, and observes status.
   modport master (
      output D_IN, ENQ, DEQ, CLR,
      input  FULL_N, EMPTY_N, D_OUT, COUNT, AFULL, OVF, UDF
   );

   // The FIFO itself.
   modport slave (
      input  D_IN, ENQ, DEQ, CLR,
      output FULL_N, EMPTY_N, D_OUT, COUNT, AFULL, OVF, UDF
   );

endinterface

// File: rtl/fifol_n.sv
// Depth-N loopy FIFO with occupancy count, almost-full flag and sticky
// overflow/underflow flags.
// When the FIFO is full, it still takes a write in the same cycle as a read.
// Storage is a circular buffer of `depth` words with explicit wrap pointers,
// so depth does not have to be a power of two.
// The storage array is not reset. D_OUT is meaningful only while EMPTY_N=1.
module fifol_n #(
   parameter int width        = 1,
   parameter int depth        = 4,
   parameter int afull_thresh = depth - 1
) (
   input logic          CLK,
   input logic          RST,
   fifol_n_if.slave     bus
);

   localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
   localparam int cnt_w = $clog2(depth + 1);

   localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(depth - 1);
   localparam logic [cnt_w-1:0] depth_c   = cnt_w'(depth);
   localparam logic [cnt_w-1:0] thresh_c  = cnt_w'(afull_thresh);
   localparam logic [cnt_w-1:0] one_c     = cnt_w'(1);

   // Registered state.
   logic [width-1:0] mem_q [depth];
   logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [cnt_w-1:0] count_q,  count_d;
   logic             ovf_q,    ovf_d;
   logic             udf_q,    udf_d;

   // Decoded status and the operations that actually happen this cycle.
   logic full;
   logic empty;
   logic do_enq;
   logic do_deq;
   logic wr_en;

   // Status decode, with the operation qualification for this cycle.
   // A DEQ on an empty FIFO is never taken, even if an ENQ comes in the same
   // cycle. There is no fall-through path.
   always_comb begin
      full   = (count_q == depth_c);
      empty  = (count_q == '0);
      do_deq = bus.DEQ && !empty;
      do_enq = bus.ENQ && (!full || bus.DEQ);
      // CLR drops the whole cycle, including any write.
      wr_en  = do_enq && !bus.CLR;
   end

   // Next-state for the pointers, the count and the sticky error flags.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;

      if (bus.CLR) begin
         // Only a hard reset clears the error flags. A clear leaves them alone.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_enq) begin
            wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_w'(1);
         end
         if (do_deq) begin
            rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_w'(1);
         end

         unique case ({do_enq, do_deq})
            2'b10:   count_d = count_q + one_c;
            2'b01:   count_d = count_q - one_c;
            default: count_d = count_q;
         endcase

         if (bus.ENQ && full && !bus.DEQ) begin
            ovf_d = 1'b1;
         end
         if (bus.DEQ && empty) begin
            udf_d = 1'b1;
         end
      end
   end

   // Control registers, cleared asynchronously by RST.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage write port. It has no reset.
   // When the FIFO is full and a read and write happen together, the write
   // lands on the slot being read. That is safe because the read is consumed
   // at this edge.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= bus.D_IN;
      end
   end

   // Outputs.
   // FULL_N is the only output with a combinational input path (from DEQ).
   assign bus.FULL_N  = !full || bus.DEQ;
   assign bus.EMPTY_N = !empty;
   assign bus.D_OUT   = mem_q[rd_ptr_q];
   assign bus.COUNT   = count_q;
   assign bus.AFULL   = (count_q >= thresh_c);
   assign bus.OVF     = ovf_q;
   assign bus.UDF     = udf_q;

endmodule

// File: tb/tb_fifol_n.sv
// Directed bench for fifol_n.
// It uses one depth-4 instance and one depth-3 instance.
module tb_fifol_n;

  logic CLK;
  logic RST;

  fifol_n_if #(.width(8), .depth(4)) a_if ();
  fifol_n_if #(.width(8), .depth(3)) b_if ();

  fifol_n #(.width(8), .depth(4), .afull_thresh(3)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (a_if.slave)
  );

  fifol_n #(.width(8), .depth(3), .afull_thresh(2)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (b_if.slave)
  );

  // Clock / reset.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_a(input logic enq, input logic [7:0] din, input logic deq, input logic clr);
    a_if.ENQ  = enq;
    a_if.D_IN = din;
    a_if.DEQ  = deq;
    a_if.CLR  = clr;
    #1;
  endtask

  task automatic set_b(input logic enq, input logic [7:0] din, input logic deq);
    b_if.ENQ  = enq;
    b_if.D_IN = din;
    b_if.DEQ  = deq;
    b_if.CLR  = 1'b0;
    #1;
  endtask

  // Perform one legal cycle on A, scoring D_OUT against the expected queue.
  task automatic op_a(input logic enq, input logic [7:0] din, input logic deq);
    logic [7:0] e;
    set_a(enq, din, deq, 1'b0);
    if (deq) begin
      e = exp_q.pop_front();
      check("a_dout", 32'(a_if.D_OUT), 32'(e));
      check("a_full_n_deq", 32'(a_if.FULL_N), 1);
    end
    if (enq) exp_q.push_back(din);
    tick();
  endtask

  // Perform one legal cycle on B, scoring data, count and almost-full.
  task automatic op_b(input logic enq, input logic [7:0] din, input logic deq);
    logic [7:0] e;
    set_b(enq, din, deq);
    if (deq) begin
      e = exp_q.pop_front();
      check("b_dout", 32'(b_if.D_OUT), 32'(e));
    end
    if (enq) exp_q.push_back(din);
    tick();
    check("b_count", 32'(b_if.COUNT), 32'(exp_q.size()));
    check("b_afull", 32'(b_if.AFULL), (exp_q.size() >= 2) ? 1 : 0);
  endtask

  int b_enq[15] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1};
  int b_deq[15] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0};

  initial begin
    logic [7:0] v;

    RST = 1'b1;
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    set_b(1'b0, 8'h00, 1'b0);
    #10;
    // Reset state.
    check("rst_empty_n", 32'(a_if.EMPTY_N), 0);
    check("rst_count",   32'(a_if.COUNT),   0);
    check("rst_afull",   32'(a_if.AFULL),   0);
    check("rst_ovf",     32'(a_if.OVF),     0);
    check("rst_udf",     32'(a_if.UDF),     0);
    check("rst_full_n",  32'(a_if.FULL_N),  1);
    RST = 1'b0;

    // Fill with A1..A4.
    for (int i = 0; i < 4; i++) begin
      v = 8'hA1 + 8'(i);
      set_a(1'b1, v, 1'b0, 1'b0);
      exp_q.push_back(v);
      tick();
      check("fill_count",   32'(a_if.COUNT),   32'(i + 1));
      check("fill_empty_n", 32'(a_if.EMPTY_N), 1);
      check("fill_afull",   32'(a_if.AFULL),   (i + 1 >= 3) ? 1 : 0);
    end
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("full_full_n", 32'(a_if.FULL_N), 0);
    check("full_head",   32'(a_if.D_OUT),  32'h A1);

    // Drain 2, refill 2, drain 4 across the wrap.
    op_a(1'b0, 8'h00, 1'b1);
    op_a(1'b0, 8'h00, 1'b1);
    check("drain2_count", 32'(a_if.COUNT), 2);
    op_a(1'b1, 8'hB1, 1'b0);
    op_a(1'b1, 8'hB2, 1'b0);
    check("refill_count", 32'(a_if.COUNT), 4);
    for (int i = 0; i < 4; i++) op_a(1'b0, 8'h00, 1'b1);
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("drain_count",   32'(a_if.COUNT),   0);
    check("drain_empty_n", 32'(a_if.EMPTY_N), 0);
    check("drain_ovf",     32'(a_if.OVF),     0);
    check("drain_udf",     32'(a_if.UDF),     0);

    // Full pass-through: fill, then 6 cycles of ENQ+DEQ at full.
    for (int i = 0; i < 4; i++) op_a(1'b1, 8'h10 + 8'(i), 1'b0);
    check("pt_fill_count", 32'(a_if.COUNT), 4);
    for (int i = 0; i < 6; i++) begin
      op_a(1'b1, 8'hC0 + 8'(i), 1'b1);
      check("pt_count", 32'(a_if.COUNT), 4);
    end
    check("pt_head", 32'(a_if.D_OUT), 32'h C2);

    // Overflow: write at full without read is dropped.
    set_a(1'b1, 8'hEE, 1'b0, 1'b0);
    tick();
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_flag",  32'(a_if.OVF),   1);
    check("ovf_udf",   32'(a_if.UDF),   0);
    check("ovf_count", 32'(a_if.COUNT), 4);
    for (int i = 0; i < 4; i++) op_a(1'b0, 8'h00, 1'b1);
    check("ovf_drain_count", 32'(a_if.COUNT), 0);

    // Underflow: DEQ+ENQ at empty -> read ignored, write taken, no fall-through.
    set_a(1'b1, 8'h55, 1'b1, 1'b0);
    tick();
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("udf_flag",    32'(a_if.UDF),     1);
    check("udf_count",   32'(a_if.COUNT),   1);
    check("udf_empty_n", 32'(a_if.EMPTY_N), 1);
    check("udf_dout",    32'(a_if.D_OUT),   32'h55);

    // CLR wins over ENQ/DEQ and leaves the sticky flags set.
    set_a(1'b1, 8'h66, 1'b1, 1'b1);
    tick();
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_count",   32'(a_if.COUNT),   0);
    check("clr_empty_n", 32'(a_if.EMPTY_N), 0);
    check("clr_ovf",     32'(a_if.OVF),     1);
    check("clr_udf",     32'(a_if.UDF),     1);

    // Async reset between edges at COUNT=2.
    op_a(1'b1, 8'h21, 1'b0);
    op_a(1'b1, 8'h22, 1'b0);
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("ar_pre_count", 32'(a_if.COUNT), 2);
    #1;
    RST = 1'b1;
    #1;
    check("ar_count",   32'(a_if.COUNT),   0);
    check("ar_empty_n", 32'(a_if.EMPTY_N), 0);
    check("ar_ovf",     32'(a_if.OVF),     0);
    check("ar_udf",     32'(a_if.UDF),     0);
    check("ar_full_n",  32'(a_if.FULL_N),  1);
    #1;
    RST = 1'b0;
    exp_q.delete();
    op_a(1'b1, 8'h77, 1'b0);
    check("ar_post_count", 32'(a_if.COUNT), 1);
    op_a(1'b0, 8'h00, 1'b1);
    set_a(1'b0, 8'h00, 1'b0, 1'b0);

    // Depth-3 instance: spaced ENQ/DEQ pattern with pointer wrap.
    for (int i = 0; i < 15; i++) begin
      op_b(b_enq[i] != 0, 8'h30 + 8'(i), b_deq[i] != 0);
    end
    set_b(1'b0, 8'h00, 1'b0);
    check("b_full_n", 32'(b_if.FULL_N), 0);
    for (int i = 0; i < 3; i++) op_b(1'b0, 8'h00, 1'b1);
    set_b(1'b0, 8'h00, 1'b0);
    check("b_empty_n", 32'(b_if.EMPTY_N), 0);
    check("b_ovf",     32'(b_if.OVF),     0);
    check("b_udf",     32'(b_if.UDF),     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
